// File: rtl/keycode_move_ctrl.sv
`default_nettype none
// keycode_move_ctrl: filters a held HID keycode into debounced, auto-repeating
// move commands (valid/ready, one-deep) plus a new-game pulse.  Rev 1.0
module keycode_move_ctrl #(
    parameter int STABLE_FRAMES = 2,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       new_game,
    output logic [7:0] drop_cnt
);

    localparam logic [3:0] SF     = STABLE_FRAMES[3:0];
    localparam logic [7:0] DELAY  = REPEAT_DELAY[7:0];
    localparam logic [7:0] PERIOD = REPEAT_PERIOD[7:0];
    localparam logic [7:0] KEY_R  = 8'h15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // {is_direction, direction}
    function automatic logic [2:0] decode(input logic [7:0] k);
        case (k)
            8'h1A, 8'h52: decode = 3'b1_00;
            8'h16, 8'h51: decode = 3'b1_01;
            8'h04, 8'h50: decode = 3'b1_10;
            8'h07, 8'h4F: decode = 3'b1_11;
            default:      decode = 3'b0_00;
        endcase
    endfunction

    logic [7:0] sample, sample_nxt;
    logic [3:0] stab, stab_nxt;
    logic [7:0] acc_key, acc_nxt;
    logic       same, acc_upd, key_chg;
    logic [2:0] dec;

    state_t     state, state_nxt;
    logic [7:0] rcnt, rcnt_nxt;
    logic       emit, ng_nxt, handshake;

    always_comb begin
        same       = (keycode == sample);
        sample_nxt = sample;
        stab_nxt   = stab;
        if (same) begin
            if (stab != SF) begin
                stab_nxt = stab + 4'd1;
            end
        end else begin
            sample_nxt = keycode;
            stab_nxt   = 4'd1;
        end
        // Accept only on the edge where the counter arrives at SF, not while parked there.
        acc_upd = (stab_nxt == SF) && ((stab != SF) || !same);
        acc_nxt = acc_upd ? sample_nxt : acc_key;
        key_chg = (acc_nxt != acc_key);
        dec     = decode(acc_nxt);
    end

    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        emit      = 1'b0;
        ng_nxt    = key_chg && (acc_nxt == KEY_R);
        if (key_chg) begin
            if (dec[2]) begin
                emit      = 1'b1;
                rcnt_nxt  = DELAY;
                state_nxt = HOLD;
            end else begin
                rcnt_nxt  = 8'd0;
                state_nxt = IDLE;
            end
        end else begin
            case (state)
                HOLD, REPEAT: begin
                    if (rcnt == 8'd1) begin
                        if (REPEAT_EN) begin
                            emit      = 1'b1;
                            rcnt_nxt  = PERIOD;
                            state_nxt = REPEAT;
                        end else begin
                            rcnt_nxt  = 8'd0;
                            state_nxt = HOLD;
                        end
                    end else if (rcnt != 8'd0) begin
                        rcnt_nxt = rcnt - 8'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sample   <= 8'h00;
            stab     <= 4'd0;
            acc_key  <= 8'h00;
            state    <= IDLE;
            rcnt     <= 8'd0;
            new_game <= 1'b0;
        end else begin
            sample   <= sample_nxt;
            stab     <= stab_nxt;
            acc_key  <= acc_nxt;
            state    <= state_nxt;
            rcnt     <= rcnt_nxt;
            new_game <= ng_nxt;
        end
    end

    assign handshake = move_valid && move_ready;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            move_valid <= 1'b0;
            move_dir   <= 2'd0;
            drop_cnt   <= 8'd0;
        end else if (emit && (!move_valid || handshake)) begin
            move_valid <= 1'b1;
            move_dir   <= dec[1:0];
        end else if (emit) begin
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (handshake) begin
            move_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keycode_move_ctrl.sv
`default_nettype none
// tb_keycode_move_ctrl: directed scenarios plus random key/ready traffic,
// checked against a frame-age based behavioural model.
module tb_keycode_move_ctrl;

    localparam int SF     = 2;
    localparam bit REP_EN = 1'b1;
    localparam int DELAY  = 30;
    localparam int PERIOD = 10;

    logic       frame_clk = 1'b0;
    logic       Reset_n   = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       new_game;
    logic [7:0] drop_cnt;

    int pass_cnt = 0;
    int total    = 0;

    keycode_move_ctrl #(
        .STABLE_FRAMES(SF), .REPEAT_EN(REP_EN),
        .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
    ) dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
        .move_ready(move_ready), .move_valid(move_valid), .move_dir(move_dir),
        .new_game(new_game), .drop_cnt(drop_cnt)
    );

    always #5 frame_clk = ~frame_clk;

    // Reference model: run length of the raw key, age of the accepted key in frames.
    function automatic int dir_of(input logic [7:0] k);
        case (k)
            8'h1A, 8'h52: return 0;
            8'h16, 8'h51: return 1;
            8'h04, 8'h50: return 2;
            8'h07, 8'h4F: return 3;
            default:      return -1;
        endcase
    endfunction

    int         m_run, m_age, m_old, m_d;
    logic [7:0] m_last, m_acc;
    logic       m_valid, m_ng, m_upd, m_chg, m_ev, m_hs;
    logic [1:0] m_dir;
    logic [7:0] m_drop;

    always @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_run = 0; m_age = 0; m_last = 8'h00; m_acc = 8'h00;
            m_valid = 1'b0; m_dir = 2'd0; m_ng = 1'b0; m_drop = 8'd0;
        end else begin
            if (keycode == m_last) begin
                m_old = m_run;
                m_run = (m_run < SF) ? m_run + 1 : SF;
                m_upd = (m_run == SF) && (m_old != SF);
            end else begin
                m_last = keycode;
                m_run  = 1;
                m_upd  = (SF == 1);
            end
            m_chg = m_upd && (m_last != m_acc);
            if (m_chg) begin
                m_acc = m_last;
                m_age = 0;
            end else if (m_age < 100000) begin
                m_age = m_age + 1;
            end
            m_ng = m_chg && (m_acc == 8'h15);
            m_d  = dir_of(m_acc);
            m_ev = (m_d >= 0) && ((m_age == 0) ||
                   (REP_EN && m_age >= DELAY && ((m_age - DELAY) % PERIOD) == 0));
            m_hs = m_valid && move_ready;
            if (m_ev && (!m_valid || m_hs)) begin
                m_valid = 1'b1;
                m_dir   = m_d[1:0];
            end else if (m_ev) begin
                if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            end else if (m_hs) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick(input logic [7:0] k, input logic r);
        keycode    = k;
        move_ready = r;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; keycode = 8'h1A; move_ready = 1'b0;
        repeat (2) @(posedge frame_clk);
        #1;
        total++;
        if ({move_valid, move_dir, new_game, drop_cnt} !== 12'd0)
            $display("FAIL reset: got v=%b d=%0d ng=%b drop=%0d, want all 0",
                     move_valid, move_dir, new_game, drop_cnt);
        else pass_cnt++;
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(8'h00, 1'b1);
            total++;
            if ({move_valid, move_dir, new_game, drop_cnt} !== {m_valid, m_dir, m_ng, m_drop})
                $display("FAIL reset_idle %0d: got v=%b d=%0d ng=%b drop=%0d, want v=%b d=%0d ng=%b drop=%0d",
                         i, move_valid, move_dir, new_game, drop_cnt, m_valid, m_dir, m_ng, m_drop);
            else pass_cnt++;
        end
    endtask

    task automatic test_tap();
        for (int i = 1; i <= 8; i++) begin
            tick((i <= 3) ? 8'h04 : 8'h00, 1'b1);
            total++;
            if (move_valid !== (i == 2) || (i == 2 && move_dir !== 2'd2))
                $display("FAIL tap edge %0d: got v=%b d=%0d, want v=%b d=2",
                         i, move_valid, move_dir, (i == 2));
            else pass_cnt++;
            total++;
            if ({move_valid, move_dir, new_game, drop_cnt} !== {m_valid, m_dir, m_ng, m_drop})
                $display("FAIL tap_model %0d: got v=%b d=%0d ng=%b drop=%0d, want v=%b d=%0d ng=%b drop=%0d",
                         i, move_valid, move_dir, new_game, drop_cnt, m_valid, m_dir, m_ng, m_drop);
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        logic [7:0] seq [5] = '{8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            tick(seq[i], 1'b1);
            total++;
            if (move_valid !== 1'b0 || drop_cnt !== 8'd0)
                $display("FAIL glitch %0d: got v=%b drop=%0d, want v=0 drop=0",
                         i, move_valid, drop_cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold_repeat();
        int n_ev = 0;
        logic exp_v;
        for (int i = 1; i <= 70; i++) begin
            tick((i <= 60) ? 8'h1A : 8'h00, 1'b1);
            exp_v = (i == 2) || (i == 32) || (i == 42) || (i == 52);
            if (move_valid) n_ev++;
            total++;
            if (move_valid !== exp_v || (exp_v && move_dir !== 2'd0))
                $display("FAIL hold_repeat edge %0d: got v=%b d=%0d, want v=%b d=0",
                         i, move_valid, move_dir, exp_v);
            else pass_cnt++;
        end
        total++;
        if (n_ev != 4)
            $display("FAIL hold_repeat_count: got %0d events, want 4", n_ev);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        for (int i = 1; i <= 10; i++) begin
            tick((i <= 4) ? 8'h16 : ((i <= 8) ? 8'h4F : 8'h00), 1'b0);
            total++;
            if ({move_valid, move_dir, new_game, drop_cnt} !== {m_valid, m_dir, m_ng, m_drop})
                $display("FAIL backpressure_model %0d: got v=%b d=%0d ng=%b drop=%0d, want v=%b d=%0d ng=%b drop=%0d",
                         i, move_valid, move_dir, new_game, drop_cnt, m_valid, m_dir, m_ng, m_drop);
            else pass_cnt++;
        end
        total++;
        if (move_valid !== 1'b1 || move_dir !== 2'd1 || drop_cnt !== 8'd1)
            $display("FAIL backpressure_hold: got v=%b d=%0d drop=%0d, want v=1 d=1 drop=1",
                     move_valid, move_dir, drop_cnt);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick(8'h00, 1'b1);
            total++;
            if (move_valid !== 1'b0 || drop_cnt !== 8'd1)
                $display("FAIL backpressure_drain %0d: got v=%b drop=%0d, want v=0 drop=1",
                         i, move_valid, drop_cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_dir_change();
        logic exp_v;
        logic [1:0] exp_d;
        for (int i = 1; i <= 50; i++) begin
            tick((i <= 10) ? 8'h50 : ((i <= 45) ? 8'h51 : 8'h00), 1'b1);
            exp_v = (i == 2) || (i == 12) || (i == 42);
            exp_d = (i == 2) ? 2'd2 : 2'd1;
            total++;
            if (move_valid !== exp_v || (exp_v && move_dir !== exp_d))
                $display("FAIL dir_change edge %0d: got v=%b d=%0d, want v=%b d=%0d",
                         i, move_valid, move_dir, exp_v, exp_d);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [11] = '{8'h00, 8'h1A, 8'h52, 8'h16, 8'h51, 8'h04,
                                  8'h50, 8'h07, 8'h4F, 8'h15, 8'h33};
        logic [7:0] k;
        int len;
        for (int s = 0; s < 40; s++) begin
            k   = pool[$urandom_range(0, 10)];
            len = $urandom_range(1, 45);
            for (int j = 0; j < len; j++) begin
                tick(k, ($urandom_range(0, 3) != 0));
                total++;
                if ({move_valid, move_dir, new_game, drop_cnt} !== {m_valid, m_dir, m_ng, m_drop})
                    $display("FAIL random seg%0d cyc%0d key=%h: got v=%b d=%0d ng=%b drop=%0d, want v=%b d=%0d ng=%b drop=%0d",
                             s, j, k, move_valid, move_dir, new_game, drop_cnt, m_valid, m_dir, m_ng, m_drop);
                else pass_cnt++;
            end
        end
        for (int i = 0; i < 6; i++) tick(8'h00, 1'b1);
    endtask

    task automatic test_new_game_reset();
        int n_ng = 0;
        logic [7:0] base;
        for (int i = 1; i <= 24; i++) begin
            tick((i <= 20) ? 8'h15 : 8'h00, 1'b1);
            if (new_game) n_ng++;
            total++;
            if (new_game !== (i == 2) || move_valid !== 1'b0)
                $display("FAIL new_game edge %0d: got ng=%b v=%b, want ng=%b v=0",
                         i, new_game, move_valid, (i == 2));
            else pass_cnt++;
        end
        total++;
        if (n_ng != 1) $display("FAIL new_game_count: got %0d pulses, want 1", n_ng);
        else pass_cnt++;
        base = m_drop;
        for (int i = 1; i <= 35; i++) tick(8'h1A, 1'b0);
        total++;
        if (move_valid !== 1'b1 || drop_cnt !== ((base == 8'hFF) ? base : base + 8'd1))
            $display("FAIL pre_reset: got v=%b drop=%0d, want v=1 drop=%0d",
                     move_valid, drop_cnt, (base == 8'hFF) ? base : base + 8'd1);
        else pass_cnt++;
        #2;
        Reset_n = 1'b0;
        #1;
        total++;
        if (move_valid !== 1'b0 || drop_cnt !== 8'd0 || new_game !== 1'b0)
            $display("FAIL async_reset: got v=%b drop=%0d ng=%b, want all 0",
                     move_valid, drop_cnt, new_game);
        else pass_cnt++;
        keycode = 8'h00;
        @(posedge frame_clk);
        #1;
        Reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick((i <= 3) ? 8'h07 : 8'h00, 1'b1);
            total++;
            if ({move_valid, move_dir, new_game, drop_cnt} !== {m_valid, m_dir, m_ng, m_drop})
                $display("FAIL post_reset %0d: got v=%b d=%0d ng=%b drop=%0d, want v=%b d=%0d ng=%b drop=%0d",
                         i, move_valid, move_dir, new_game, drop_cnt, m_valid, m_dir, m_ng, m_drop);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_tap();
        test_glitch();
        test_hold_repeat();
        test_backpressure();
        test_dir_change();
        test_random();
        test_new_game_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire
